// File: rtl/user_obi_rr_arb.sv
// Round-robin arbiter merging several OBI managers onto one subordinate port.
// Responses are routed back in order through an ID FIFO of granted manager indices.
module user_obi_rr_arb #(
    parameter int unsigned NumMgr    = 2,
    parameter int unsigned MaxTrans  = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumMgr-1:0]               mgr_req_i,
    input  logic [NumMgr*AddrWidth-1:0]     mgr_addr_i,
    input  logic [NumMgr-1:0]               mgr_we_i,
    input  logic [NumMgr*(DataWidth/8)-1:0] mgr_be_i,
    input  logic [NumMgr*DataWidth-1:0]     mgr_wdata_i,
    output logic [NumMgr-1:0]               mgr_gnt_o,
    output logic [NumMgr-1:0]               mgr_rvalid_o,
    output logic [DataWidth-1:0]            mgr_rdata_o,
    output logic                            mgr_err_o,
    output logic                            sbr_req_o,
    output logic [AddrWidth-1:0]            sbr_addr_o,
    output logic                            sbr_we_o,
    output logic [DataWidth/8-1:0]          sbr_be_o,
    output logic [DataWidth-1:0]            sbr_wdata_o,
    input  logic                            sbr_gnt_i,
    input  logic                            sbr_rvalid_i,
    input  logic [DataWidth-1:0]            sbr_rdata_i,
    input  logic                            sbr_err_i,
    output logic                            proto_err_o
);

    localparam int unsigned IdxW = $clog2(NumMgr);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned BeW  = DataWidth / 8;

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            proto_err_q, proto_err_d;
    logic [IdxW-1:0] fifo_q [2**PtrW];

    logic            any_req, not_full, push, pop, rr_found;
    logic [IdxW-1:0] rr_idx, winner, cand_idx, head;
    int unsigned     cand;

    // Search upward from ptr_q with wrap; first asserted request wins.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NumMgr; i++) begin
            cand     = (int'(ptr_q) + i) % NumMgr;
            cand_idx = IdxW'(cand);
            if (!rr_found && mgr_req_i[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    assign any_req   = |mgr_req_i;
    assign winner    = lock_q ? lock_idx_q : rr_idx;
    assign not_full  = (count_q < CntW'(MaxTrans));
    assign sbr_req_o = any_req & not_full;
    assign push      = sbr_req_o & sbr_gnt_i;
    assign pop       = sbr_rvalid_i & (count_q != '0);
    assign head      = fifo_q[rptr_q];

    always_comb begin
        mgr_gnt_o    = '0;
        mgr_rvalid_o = '0;
        sbr_addr_o   = '0;
        sbr_we_o     = 1'b0;
        sbr_be_o     = '0;
        sbr_wdata_o  = '0;
        if (push) mgr_gnt_o[winner] = 1'b1;
        if (pop)  mgr_rvalid_o[head] = 1'b1;
        if (any_req) begin
            sbr_addr_o  = mgr_addr_i[winner*AddrWidth +: AddrWidth];
            sbr_we_o    = mgr_we_i[winner];
            sbr_be_o    = mgr_be_i[winner*BeW +: BeW];
            sbr_wdata_o = mgr_wdata_i[winner*DataWidth +: DataWidth];
        end
    end

    assign mgr_rdata_o = pop ? sbr_rdata_i : '0;
    assign mgr_err_o   = pop & sbr_err_i;
    assign proto_err_o = proto_err_q;

    always_comb begin
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q + CntW'(push) - CntW'(pop);
        proto_err_d = proto_err_q | (sbr_rvalid_i & (count_q == '0));
        if (push) begin
            ptr_d  = (winner == IdxW'(NumMgr - 1)) ? '0 : winner + 1'b1;
            lock_d = 1'b0;
            wptr_d = (wptr_q == PtrW'(MaxTrans - 1)) ? '0 : wptr_q + 1'b1;
        end else if (sbr_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = winner;
        end else begin
            // Request withdrawn entirely: nothing left to keep stable.
            lock_d = 1'b0;
        end
        if (pop) rptr_d = (rptr_q == PtrW'(MaxTrans - 1)) ? '0 : rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            count_q     <= '0;
            rptr_q      <= '0;
            wptr_q      <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= winner;
    end

endmodule

// File: tb/tb_user_obi_rr_arb.sv
// Self-checking bench for user_obi_rr_arb: directed scenarios plus a randomized
// run compared against an in-order queue model of outstanding transactions.
module tb_user_obi_rr_arb;

    localparam int NM = 2;
    localparam int MT = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     mgr_req_i;
    logic [NM*AW-1:0]  mgr_addr_i;
    logic [NM-1:0]     mgr_we_i;
    logic [NM*BW-1:0]  mgr_be_i;
    logic [NM*DW-1:0]  mgr_wdata_i;
    logic [NM-1:0]     mgr_gnt_o, mgr_rvalid_o;
    logic [DW-1:0]     mgr_rdata_o;
    logic              mgr_err_o;
    logic              sbr_req_o, sbr_we_o;
    logic [AW-1:0]     sbr_addr_o;
    logic [BW-1:0]     sbr_be_o;
    logic [DW-1:0]     sbr_wdata_o;
    logic              sbr_gnt_i, sbr_rvalid_i, sbr_err_i;
    logic [DW-1:0]     sbr_rdata_i;
    logic              proto_err_o;

    logic [AW-1:0] s_addr  [NM];
    logic          s_we    [NM];
    logic [BW-1:0] s_be    [NM];
    logic [DW-1:0] s_wdata [NM];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_q[$];
    int m_ptr;
    int m_lock;
    bit m_perr;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            mgr_addr_i[i*AW +: AW]  = s_addr[i];
            mgr_we_i[i]             = s_we[i];
            mgr_be_i[i*BW +: BW]    = s_be[i];
            mgr_wdata_i[i*DW +: DW] = s_wdata[i];
        end
    end

    user_obi_rr_arb #(.NumMgr(NM), .MaxTrans(MT), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mgr_req_i(mgr_req_i), .mgr_addr_i(mgr_addr_i), .mgr_we_i(mgr_we_i),
        .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
        .mgr_gnt_o(mgr_gnt_o), .mgr_rvalid_o(mgr_rvalid_o),
        .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o),
        .sbr_req_o(sbr_req_o), .sbr_addr_o(sbr_addr_o), .sbr_we_o(sbr_we_o),
        .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o),
        .sbr_gnt_i(sbr_gnt_i), .sbr_rvalid_i(sbr_rvalid_i),
        .sbr_rdata_i(sbr_rdata_i), .sbr_err_i(sbr_err_i),
        .proto_err_o(proto_err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fixed_fields();
        for (int i = 0; i < NM; i++) begin
            s_addr[i]  = 32'hA000_0000 + 32'(i) * 32'h100;
            s_we[i]    = i[0];
            s_be[i]    = 4'hF - 4'(i);
            s_wdata[i] = 32'h5A5A_0000 + 32'(i);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        mgr_req_i    = '0;
        sbr_gnt_i    = 1'b0;
        sbr_rvalid_i = 1'b0;
        sbr_err_i    = 1'b0;
        sbr_rdata_i  = '0;
        set_fixed_fields();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_q.delete();
        m_ptr  = 0;
        m_lock = -1;
        m_perr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        mgr_req_i    = '0;
        sbr_gnt_i    = 1'b1;
        sbr_rvalid_i = 1'b1;
        sbr_err_i    = 1'b1;
        sbr_rdata_i  = 32'hDEAD_BEEF;
        set_fixed_fields();
        #4;
        checks++;
        if ({sbr_req_o, sbr_we_o, mgr_err_o, proto_err_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b expected 0000", {sbr_req_o, sbr_we_o, mgr_err_o, proto_err_o});
        end
        checks++;
        if ({mgr_gnt_o, mgr_rvalid_o} !== '0) begin
            errors++;
            $display("FAIL reset_gnt_rvalid got %b expected 0", {mgr_gnt_o, mgr_rvalid_o});
        end
        checks++;
        if ({sbr_addr_o, sbr_be_o, sbr_wdata_o, mgr_rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h expected 0", {sbr_addr_o, sbr_be_o, sbr_wdata_o, mgr_rdata_o});
        end
        do_reset();
    endtask

    task automatic test_alternate();
        logic [NM-1:0] exp_g [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [NM-1:0] exp_r [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        sbr_gnt_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mgr_req_i    = (c < 4) ? 2'b11 : 2'b00;
            sbr_rvalid_i = (c > 0);
            sbr_rdata_i  = 32'h1000 + 32'(c);
            #4;
            checks++;
            if (mgr_gnt_o !== exp_g[c]) begin
                errors++;
                $display("FAIL alt_gnt cycle %0d got %b expected %b", c, mgr_gnt_o, exp_g[c]);
            end
            checks++;
            if (mgr_rvalid_o !== exp_r[c]) begin
                errors++;
                $display("FAIL alt_rvalid cycle %0d got %b expected %b", c, mgr_rvalid_o, exp_r[c]);
            end
            if (c > 0) begin
                checks++;
                if (mgr_rdata_o !== 32'h1000 + 32'(c)) begin
                    errors++;
                    $display("FAIL alt_rdata cycle %0d got %h expected %h", c, mgr_rdata_o, 32'h1000 + 32'(c));
                end
            end
            tick();
        end
        sbr_rvalid_i = 1'b0;
        sbr_gnt_i    = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            mgr_req_i = (c == 1) ? 2'b10 : 2'b11;
            sbr_gnt_i = (c >= 4);
            #4;
            checks++;
            if (sbr_addr_o !== ((c <= 4) ? s_addr[1] : s_addr[0])) begin
                errors++;
                $display("FAIL lock_addr cycle %0d got %h expected %h", c, sbr_addr_o,
                         (c <= 4) ? s_addr[1] : s_addr[0]);
            end
            checks++;
            if (mgr_gnt_o !== ((c < 4) ? 2'b00 : (c == 4) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL lock_gnt cycle %0d got %b expected %b", c, mgr_gnt_o,
                         (c < 4) ? 2'b00 : (c == 4) ? 2'b10 : 2'b01);
            end
            tick();
        end
        mgr_req_i = '0;
        sbr_gnt_i = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        mgr_req_i = 2'b11;
        sbr_gnt_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            sbr_rvalid_i = (c == 4);
            #4;
            checks++;
            if (sbr_req_o !== (c < 2 || c == 5)) begin
                errors++;
                $display("FAIL full_req cycle %0d got %b expected %b", c, sbr_req_o, (c < 2 || c == 5));
            end
            checks++;
            if (mgr_gnt_o !== ((c == 0 || c == 5) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL full_gnt cycle %0d got %b expected %b", c, mgr_gnt_o,
                         (c == 0 || c == 5) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00);
            end
            if (c == 4) begin
                checks++;
                if (mgr_rvalid_o !== 2'b01) begin
                    errors++;
                    $display("FAIL full_rvalid got %b expected 01", mgr_rvalid_o);
                end
            end
            tick();
        end
        mgr_req_i    = '0;
        sbr_gnt_i    = 1'b0;
        sbr_rvalid_i = 1'b0;
    endtask

    task automatic test_proto_err();
        do_reset();
        sbr_rvalid_i = 1'b1;
        #4;
        checks++;
        if (mgr_rvalid_o !== 2'b00 || proto_err_o !== 1'b0) begin
            errors++;
            $display("FAIL proto_first got rvalid %b perr %b expected 00 0", mgr_rvalid_o, proto_err_o);
        end
        tick();
        sbr_rvalid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #4;
            checks++;
            if (proto_err_o !== 1'b1) begin
                errors++;
                $display("FAIL proto_sticky cycle %0d got %b expected 1", c, proto_err_o);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [NM-1:0] exp_r [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
        do_reset();
        sbr_gnt_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mgr_req_i    = (c == 0) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00;
            sbr_rvalid_i = (c >= 1 && c <= 3);
            #4;
            if (c < 4) begin
                checks++;
                if (mgr_rvalid_o !== exp_r[c]) begin
                    errors++;
                    $display("FAIL b2b_rvalid cycle %0d got %b expected %b", c, mgr_rvalid_o, exp_r[c]);
                end
            end
            if (c == 1) begin
                checks++;
                if (mgr_gnt_o !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_gnt got %b expected 10", mgr_gnt_o);
                end
            end
            if (c == 4) begin
                checks++;
                if (proto_err_o !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_perr got %b expected 1", proto_err_o);
                end
            end
            tick();
        end
        sbr_rvalid_i = 1'b0;
        sbr_gnt_i    = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        mgr_req_i = 2'b01;
        sbr_gnt_i = 1'b1;
        tick();
        tick();
        sbr_gnt_i = 1'b0;
        mgr_req_i = 2'b11;
        #2;
        checks++;
        if (sbr_req_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_full got %b expected 0", sbr_req_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sbr_req_o !== 1'b1 || proto_err_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got req %b perr %b expected 1 0", sbr_req_o, proto_err_o);
        end
        tick();
        rst_n     = 1'b1;
        sbr_gnt_i = 1'b1;
        #4;
        checks++;
        if (mgr_gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL mid_ptr got %b expected 01", mgr_gnt_o);
        end
        tick();
        mgr_req_i    = '0;
        sbr_gnt_i    = 1'b0;
        sbr_rvalid_i = 1'b1;
        #4;
        checks++;
        if (mgr_rvalid_o !== 2'b01) begin
            errors++;
            $display("FAIL mid_rvalid got %b expected 01", mgr_rvalid_o);
        end
        tick();
        #4;
        checks++;
        if (mgr_rvalid_o !== 2'b00) begin
            errors++;
            $display("FAIL mid_stale got %b expected 00", mgr_rvalid_o);
        end
        tick();
        sbr_rvalid_i = 1'b0;
        #4;
        checks++;
        if (proto_err_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_perr got %b expected 1", proto_err_o);
        end
        tick();
    endtask

    task automatic test_random();
        logic [NM-1:0] e_gnt, e_rv;
        logic          e_req, e_any, e_pop;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_rdata;
        logic          e_we, e_err;
        logic [BW-1:0] e_be;
        int            win;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int m = 0; m < NM; m++) begin
                if (!mgr_req_i[m] && ($urandom_range(0, 1) == 1)) begin
                    mgr_req_i[m] = 1'b1;
                    s_addr[m]    = $urandom;
                    s_we[m]      = 1'($urandom);
                    s_be[m]      = 4'($urandom);
                    s_wdata[m]   = $urandom;
                end
            end
            sbr_gnt_i    = ($urandom_range(0, 2) != 0);
            sbr_rvalid_i = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1)
                                            : (cyc > 2500 && $urandom_range(0, 40) == 0);
            sbr_rdata_i  = $urandom;
            sbr_err_i    = 1'($urandom);
            #4;
            // Model: in-order list of granted IDs, rotating priority, sticky request hold.
            e_any = |mgr_req_i;
            win   = 0;
            if (m_lock >= 0) win = m_lock;
            else begin
                for (int k = NM - 1; k >= 0; k--)
                    if (mgr_req_i[(m_ptr + k) % NM]) win = (m_ptr + k) % NM;
            end
            e_req   = e_any && (m_q.size() < MT);
            e_gnt   = '0;
            if (e_req && sbr_gnt_i) e_gnt[win] = 1'b1;
            e_pop   = sbr_rvalid_i && (m_q.size() > 0);
            e_rv    = '0;
            if (e_pop) e_rv[m_q[0]] = 1'b1;
            e_addr  = e_any ? s_addr[win] : '0;
            e_we    = e_any ? s_we[win] : 1'b0;
            e_be    = e_any ? s_be[win] : '0;
            e_wdata = e_any ? s_wdata[win] : '0;
            e_rdata = e_pop ? sbr_rdata_i : '0;
            e_err   = e_pop && sbr_err_i;
            checks++;
            if ({sbr_req_o, mgr_gnt_o, mgr_rvalid_o} !== {e_req, e_gnt, e_rv}) begin
                errors++;
                $display("FAIL rnd_handshake cycle %0d got req %b gnt %b rv %b expected %b %b %b",
                         cyc, sbr_req_o, mgr_gnt_o, mgr_rvalid_o, e_req, e_gnt, e_rv);
            end
            checks++;
            if ({sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o} !== {e_addr, e_we, e_be, e_wdata}) begin
                errors++;
                $display("FAIL rnd_fields cycle %0d got %h %b %h %h expected %h %b %h %h", cyc,
                         sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o, e_addr, e_we, e_be, e_wdata);
            end
            checks++;
            if ({mgr_rdata_o, mgr_err_o, proto_err_o} !== {e_rdata, e_err, m_perr}) begin
                errors++;
                $display("FAIL rnd_resp cycle %0d got %h %b %b expected %h %b %b", cyc,
                         mgr_rdata_o, mgr_err_o, proto_err_o, e_rdata, e_err, m_perr);
            end
            if (sbr_rvalid_i && m_q.size() == 0) m_perr = 1'b1;
            if (e_pop) void'(m_q.pop_front());
            if (e_req && sbr_gnt_i) begin
                m_q.push_back(win);
                m_ptr  = (win + 1) % NM;
                m_lock = -1;
            end else if (e_req) m_lock = win;
            else m_lock = -1;
            tick();
            mgr_req_i = mgr_req_i & ~e_gnt;
        end
        mgr_req_i    = '0;
        sbr_gnt_i    = 1'b0;
        sbr_rvalid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_lock();
        test_full();
        test_proto_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
